// File: rtl/loop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : loop_sequencer
// Description : Control stage in front of the loop address generator. It
//               accepts a loop command (valid/ready), programs the generator,
//               then for every iteration issues one memory request at
//               base + generator offset, waits for the ack and steps the
//               generator. The loop ends when the generator's loop flag
//               drops or MAX_ITER iterations have completed, and done
//               pulses for one cycle.
// Ports       : clock, reset          - clock, async active-high reset
//               cmd_*                 - loop command handshake and fields
//               gen_*                 - generator programming / feedback
//               mem_req/addr/ack      - memory request handshake
//               busy, done, limit_hit - status
//               iter_count            - iterations of current/last loop
// Revision    : 1.0 - initial release
// ============================================================================
module loop_sequencer #(
    parameter int SETTLE_CYCLES = 2,    // >= 2
    parameter int MAX_ITER      = 1024  // >= 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_reg_index,
    input  logic [31:0] cmd_threshold,
    input  logic [31:0] cmd_increment,
    input  logic [31:0] cmd_base,
    output logic [4:0]  gen_register_index,
    output logic [31:0] gen_threshold,
    output logic [31:0] gen_increment,
    output logic        gen_initialize_WE,
    output logic        gen_increase_address,
    input  logic [31:0] gen_address,
    input  logic        gen_loop,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        limit_hit,
    output logic [31:0] iter_count
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_init   = 3'd1;
    localparam logic [2:0] c_settle = 3'd2;
    localparam logic [2:0] c_check  = 3'd3;
    localparam logic [2:0] c_req    = 3'd4;
    localparam logic [2:0] c_step   = 3'd5;
    localparam logic [2:0] c_done   = 3'd6;

    localparam int          c_cnt_w     = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    // The counter is loaded in INIT/STEP and SETTLE exits when it reads
    // zero, so loading N-1 yields exactly N SETTLE cycles.
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [31:0] c_max_iter  = 32'(MAX_ITER);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_cnt_w-1:0] r_settle;
    logic [4:0]         r_index;
    logic [31:0]        r_threshold;
    logic [31:0]        r_increment;
    logic [31:0]        r_base;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_iter;
    logic               r_limit;

    logic w_idle;
    logic w_init;
    logic w_step;
    logic w_req;
    logic w_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:   if (cmd_valid) w_next = c_init;
            c_init:   w_next = c_settle;
            c_settle: if (r_settle == '0) w_next = c_check;
            c_check: begin
                if (r_iter == c_max_iter) begin
                    w_next = c_done;
                end else if (gen_loop) begin
                    w_next = c_req;
                end else begin
                    w_next = c_done;
                end
            end
            c_req:    if (mem_ack) w_next = c_step;
            c_step:   w_next = c_settle;
            c_done:   w_next = c_idle;
            default:  w_next = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_idle = 1'b0;
        w_init = 1'b0;
        w_step = 1'b0;
        w_req  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_idle:  w_idle = 1'b1;
            c_init:  w_init = 1'b1;
            c_req:   w_req  = 1'b1;
            c_step:  w_step = 1'b1;
            c_done:  w_done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command latches, settle counter, address, iteration count
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_settle    <= '0;
            r_index     <= '0;
            r_threshold <= '0;
            r_increment <= '0;
            r_base      <= '0;
            r_mem_addr  <= '0;
            r_iter      <= '0;
            r_limit     <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (cmd_valid) begin
                        r_index     <= cmd_reg_index;
                        r_threshold <= cmd_threshold;
                        r_increment <= cmd_increment;
                        r_base      <= cmd_base;
                        r_iter      <= '0;
                        r_limit     <= 1'b0;
                    end
                end
                c_init, c_step: begin
                    r_settle <= c_settle_load;
                end
                c_settle: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                c_check: begin
                    if (r_iter == c_max_iter) begin
                        r_limit <= 1'b1;
                    end else if (gen_loop) begin
                        // Registered so the address is stable for the whole REQ.
                        r_mem_addr <= r_base + gen_address;
                    end
                end
                c_req: begin
                    if (mem_ack) begin
                        r_iter <= r_iter + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // cmd_ready is held low while reset is asserted even though the state
    // register already reads IDLE.
    assign cmd_ready            = w_idle & ~reset;
    assign busy                 = ~w_idle;
    assign gen_initialize_WE    = w_init;
    assign gen_increase_address = w_step;
    assign mem_req              = w_req;
    assign done                 = w_done;
    assign mem_addr             = r_mem_addr;
    assign gen_register_index   = r_index;
    assign gen_threshold        = r_threshold;
    assign gen_increment        = r_increment;
    assign limit_hit            = r_limit;
    assign iter_count           = r_iter;

endmodule
`default_nettype wire

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Control stage directly upstream of the loop address generator.
- Accepts a loop command over a valid/ready handshake and programs the generator (index, threshold, increment).
- Per iteration: issues one memory request at base + generator offset, waits for ack, then steps the generator.
- Terminates when the generator's loop flag drops or an iteration limit is reached, then pulses done.

Parameters:
- SETTLE_CYCLES, 2, wait cycles after any init/step pulse before sampling gen_loop; minimum legal value 2.
- MAX_ITER, 1024, iteration limit guarding against zero increments; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  loop command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_reg_index  in  5  loop register index
- cmd_threshold  in  32  loop threshold
- cmd_increment  in  32  per-iteration offset increment
- cmd_base  in  32  base address added to the generator offset
- gen_register_index  out  5  latched index to generator
- gen_threshold  out  32  latched threshold to generator
- gen_increment  out  32  latched increment to generator
- gen_initialize_WE  out  1  one-cycle init pulse
- gen_increase_address  out  1  one-cycle step pulse
- gen_address  in  32  generator offset
- gen_loop  in  1  generator continue flag
- mem_req  out  1  memory request
- mem_addr  out  32  request address
- mem_ack  in  1  request accepted
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- limit_hit  out  1  last loop ended on MAX_ITER; held until next command accept
- iter_count  out  32  iterations completed in current/last loop

Behaviour:
- Reset: asynchronous and active-high. Forces state to IDLE and clears all outputs and latches to 0, including iter_count and limit_hit. cmd_ready goes to 1 after reset deasserts.
- Reset mid-loop: abandons the loop with no done pulse. A later command re-initialises the generator, so no stale generator state is carried over.
- States: IDLE, INIT, SETTLE, CHECK, REQ, STEP, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid (sampled high): latch index, threshold, increment and base; clear iter_count and limit_hit; go to INIT.
- INIT: gen_initialize_WE=1 for exactly one cycle; load the settle counter; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to CHECK. gen_loop is ignored in this state.
- CHECK (in priority order):
  - iter_count == MAX_ITER: set limit_hit; go to DONE.
  - gen_loop == 1: register mem_addr = cmd_base + gen_address (32-bit, wraps mod 2^32); go to REQ.
  - Otherwise: go to DONE.
- REQ:
  - mem_req=1 and mem_addr stays stable until mem_ack is sampled high.
  - On ack: mem_req drops the next cycle; iter_count increments; go to STEP.
  - mem_ack outside REQ is ignored.
- STEP: gen_increase_address=1 for exactly one cycle; reload the settle counter; go to SETTLE.
- DONE: done=1 for one cycle; go to IDLE. iter_count and limit_hit hold their values.
- Generator outputs:
  - gen_register_index, gen_threshold and gen_increment are driven from the latches at all times.
  - gen_initialize_WE and gen_increase_address are never high in the same cycle.
- Latency (cycle 0 = accept edge):
  - INIT in cycle 1, SETTLE in cycles 2-3, CHECK in cycle 4.
  - First mem_req in cycle 5.
  - With ack in the same cycle as the request, each iteration takes 5 cycles (REQ, STEP, 2×SETTLE, CHECK).
- Zero-iteration loop: threshold 0 gives done in cycle 5 with iter_count=0 and no mem_req.
- Arithmetic: iter_count is 32-bit; it cannot wrap because MAX_ITER bounds it.

Test Plan:
- Reset 3 cycles -> all outputs 0 during reset; cmd_ready=1 after. Assert reset while in REQ -> mem_req and busy drop asynchronously, state returns to IDLE, no done pulse.
- Command base=0x100, threshold=12, increment=4, index=3, mem_ack tied high -> mem_addr 0x100, 0x104, 0x108; three STEP pulses; one init pulse; done with iter_count=3, limit_hit=0; first mem_req 5 cycles after accept.
- threshold=0 -> no mem_req; done 5 cycles after accept; iter_count=0.
- threshold=8, increment=4, mem_ack delayed 3 cycles per request -> mem_req held 4 cycles each with mem_addr stable; iter_count=2; gen_increase_address only after each ack.
- MAX_ITER=4, increment=0, threshold=10 -> exactly 4 requests at base; limit_hit=1; done; iter_count=4. Next command accept clears limit_hit.
- base=0xFFFFFFFC, increment=4, threshold=8 -> mem_addr 0xFFFFFFFC then 0x00000000 (wrap); cmd_valid asserted while busy -> cmd_ready=0 and the command is not accepted until IDLE.
